// File: rtl/divider_arbiter.sv
// divider_arbiter
// Shares one sequential 32-bit divider among NUM_REQ requesters with
// round-robin arbitration. Each requester offers a dividend/divisor pair.
// The arbiter runs the divider's start_division/division_active protocol and
// returns the quotient and remainder with a one-cycle strobe to the requester
// that was served.
//
// Handshake: a requester raises req_valid[i] and holds its operands stable
// until the cycle where req_ready[i] is high. The request is accepted on the
// clock edge that ends that cycle. If req_valid drops before that edge, the
// request is withdrawn. req_ready is one-hot or zero and is only raised in IDLE.
// rsp_valid[i] is a single-cycle strobe. rsp_id, rsp_quotient, rsp_remainder
// and rsp_div_by_zero are valid in that cycle and hold until the next response.
//
// Optional feature macro: DIV_ARB_ZERO_GUARD_EN
//   When defined, a zero divisor never reaches the divider. The arbiter answers
//   with quotient 32'hFFFF_FFFF, remainder = dividend and rsp_div_by_zero = 1.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     per-requester request handshake
//   req_dividend/divisor packed operands, requester i at [32i+31:32i]
//   rsp_valid/id        one-hot response strobe and index of the served requester
//   rsp_quotient/remainder/div_by_zero  response payload
//   busy                high in every state except IDLE
//   start_division, dividend, divisor   to the divider
//   quotient, remainder, division_active from the divider
//   dbg_state           current FSM state (IDLE=0, START=1, WAIT_DONE=2, RESP=3)
module divider_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [32*NUM_REQ-1:0]   req_dividend,
   input  logic [32*NUM_REQ-1:0]   req_divisor,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [31:0]             rsp_quotient,
   output logic [31:0]             rsp_remainder,
   output logic                    rsp_div_by_zero,
   output logic                    busy,
   output logic                    start_division,
   output logic [31:0]             dividend,
   output logic [31:0]             divisor,
   input  logic [31:0]             quotient,
   input  logic [31:0]             remainder,
   input  logic                    division_active,
   output logic [1:0]              dbg_state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      RESP      = 2'd3
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] lat_id;
   logic [ID_W-1:0] grant_idx;
   logic            grant_found;
   logic [ID_W:0]   cand;
   logic [31:0]     sel_dividend;
   logic [31:0]     sel_divisor;
   logic            load_div;
   logic            load_zero;

   // Round-robin search. Candidates are visited from last_grant+1 upward,
   // wrapping modulo NUM_REQ. The first valid candidate wins. cand is one bit
   // wider so the sum cannot overflow before the single wrap subtraction.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last_grant} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   // Operand mux for the winning requester
   always_comb begin
      sel_dividend = '0;
      sel_divisor  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_dividend = req_dividend[i*32 +: 32];
            sel_divisor  = req_divisor[i*32 +: 32];
         end
      end
   end

   // Next-state and control decode
   always_comb begin
      state_next     = state;
      start_division = 1'b0;
      load_div       = 1'b0;
      load_zero      = 1'b0;
      case (state)
         IDLE: begin
            if (grant_found) state_next = START;
         end
         START: begin
`ifdef DIV_ARB_ZERO_GUARD_EN
            if (divisor == 32'd0) begin
               load_zero  = 1'b1;
               state_next = RESP;
            end else begin
               start_division = 1'b1;
               if (division_active) state_next = WAIT_DONE;
            end
`else
            start_division = 1'b1;
            if (division_active) state_next = WAIT_DONE;
`endif
         end
         WAIT_DONE: begin
            if (!division_active) begin
               load_div   = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
      if (state == RESP) rsp_valid[lat_id] = 1'b1;
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

   // dividend/divisor are the latched operand registers themselves, so they
   // stay stable from START through WAIT_DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         last_grant    <= ID_W'(NUM_REQ-1);
         lat_id        <= '0;
         dividend      <= '0;
         divisor       <= '0;
         rsp_id        <= '0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && grant_found) begin
            lat_id     <= grant_idx;
            last_grant <= grant_idx;
            dividend   <= sel_dividend;
            divisor    <= sel_divisor;
         end
         if (load_div) begin
            rsp_id        <= lat_id;
            rsp_quotient  <= quotient;
            rsp_remainder <= remainder;
         end
         if (load_zero) begin
            rsp_id        <= lat_id;
            rsp_quotient  <= 32'hFFFF_FFFF;
            rsp_remainder <= dividend;
         end
      end
   end

`ifdef DIV_ARB_ZERO_GUARD_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_div_by_zero <= 1'b0;
      end else if (load_zero) begin
         rsp_div_by_zero <= 1'b1;
      end else if (load_div) begin
         rsp_div_by_zero <= 1'b0;
      end
   end
`else
   assign rsp_div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider_arbiter.sv
// Testbench for divider_arbiter: directed timing scenarios plus randomized
// multi-requester traffic, checked against a round-robin/arithmetic reference.
module tb_divider_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int EW      = 1 + ID_W + 64;
`ifdef DIV_ARB_ZERO_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NUM_REQ-1:0]    req_valid;
   logic [32*NUM_REQ-1:0] req_dividend;
   logic [32*NUM_REQ-1:0] req_divisor;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [ID_W-1:0]       rsp_id;
   logic [31:0]           rsp_quotient;
   logic [31:0]           rsp_remainder;
   logic                  rsp_div_by_zero;
   logic                  busy;
   logic                  start_division;
   logic [31:0]           dividend;
   logic [31:0]           divisor;
   logic [31:0]           div_q;
   logic [31:0]           div_r;
   logic                  div_active;
   logic [1:0]            dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [EW-1:0] exp_q[$];
   int            grant_log[$];
   int            model_last;
   bit            model_idle;

   divider_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
      .rsp_div_by_zero(rsp_div_by_zero), .busy(busy),
      .start_division(start_division), .dividend(dividend), .divisor(divisor),
      .quotient(div_q), .remainder(div_r), .division_active(div_active),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- divider stand-in ----------------
   // Random duration; outputs are noise while active and settle when it drops.
   logic [3:0]  div_cnt;
   logic [31:0] res_q;
   logic [31:0] res_r;
   always @(posedge clk) begin
      if (reset) begin
         div_active <= 1'b0;
         div_cnt    <= '0;
         div_q      <= '0;
         div_r      <= '0;
         res_q      <= '0;
         res_r      <= '0;
      end else if (!div_active) begin
         if (start_division) begin
            div_active <= 1'b1;
            div_cnt    <= 4'($urandom_range(1, 8));
            res_q      <= (divisor == 0) ? 32'hFFFF_FFFF : dividend / divisor;
            res_r      <= (divisor == 0) ? dividend : dividend % divisor;
            div_q      <= $urandom;
            div_r      <= $urandom;
         end
      end else if (div_cnt == 0) begin
         div_active <= 1'b0;
         div_q      <= res_q;
         div_r      <= res_r;
      end else begin
         div_cnt <= div_cnt - 4'd1;
         div_q   <= $urandom;
      end
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] model_result(input int id, input logic [31:0] a,
                                                  input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
      q = (b == 0) ? 32'hFFFF_FFFF : a / b;
      r = (b == 0) ? a : a % b;
      z = GUARD && (b == 0);
      return {z, ID_W'(id), q, r};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   initial begin
      int            win;
      int            c;
      logic [NUM_REQ-1:0] exp_ready;
      logic [EW-1:0] e;
      model_last = NUM_REQ - 1;
      model_idle = 1'b1;
      forever begin
         @(negedge clk);
         if (reset) begin
            model_last = NUM_REQ - 1;
            model_idle = 1'b1;
            exp_q.delete();
         end else begin
            check_eq("busy", busy, !model_idle);
            if (model_idle) begin
               check_eq("start_in_idle", start_division, 0);
               win = -1;
               for (int k = 1; k <= NUM_REQ; k++) begin
                  c = (model_last + k) % NUM_REQ;
                  if (win < 0 && req_valid[c]) win = c;
               end
               exp_ready = '0;
               if (win >= 0) exp_ready[win] = 1'b1;
               check_eq("req_ready", req_ready, exp_ready);
               if (win >= 0) begin
                  exp_q.push_back(model_result(win, req_dividend[win*32 +: 32],
                                               req_divisor[win*32 +: 32]));
                  grant_log.push_back(win);
                  model_last = win;
                  model_idle = 1'b0;
               end
            end else begin
               check_eq("req_ready_busy", req_ready, 0);
            end
            if (rsp_valid != 0) begin
               if (exp_q.size() == 0) begin
                  check_eq("rsp_unexpected", rsp_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  exp_ready = '0;
                  exp_ready[e[64 +: ID_W]] = 1'b1;
                  check_eq("rsp_valid", rsp_valid, exp_ready);
                  check_eq("rsp_id", rsp_id, e[64 +: ID_W]);
                  check_eq("rsp_quotient", rsp_quotient, e[63:32]);
                  check_eq("rsp_remainder", rsp_remainder, e[31:0]);
                  check_eq("rsp_div_by_zero", rsp_div_by_zero, e[EW-1]);
                  model_idle = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Entered and left at posedge+1.
   task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b,
                            input int patience, output bit got);
      req_dividend[id*32 +: 32] = a;
      req_divisor[id*32 +: 32]  = b;
      req_valid[id] = 1'b1;
      got = 1'b0;
      for (int w = 0; w < patience; w++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp(input int limit);
      bit seen;
      seen = 1'b0;
      for (int w = 0; w < limit; w++) begin
         @(negedge clk);
         if (rsp_valid != 0) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq("rsp_timeout", seen, 1);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
   endtask

   task automatic req_stream(input int id, input int n);
      bit          got;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      @(posedge clk); #1;
      for (int t = 0; t < n; t++) begin
         sel = $urandom_range(0, 7);
         a   = (sel[0]) ? 32'($urandom_range(0, 1000)) : $urandom;
         if (sel == 0)      b = 32'd0;
         else if (sel < 4)  b = 32'($urandom_range(1, 20));
         else               b = $urandom;
         drive_req(id, a, b, $urandom_range(1, 40), got);
         repeat ($urandom_range(0, 4)) begin
            @(posedge clk); #1;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit g0, g1, g2, g3;
      reset        = 1'b1;
      req_valid    = '0;
      req_dividend = '0;
      req_divisor  = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_start", start_division, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_dbz", rsp_div_by_zero, 0);
      check_eq("rst_rsp_id", rsp_id, 0);
      check_eq("rst_quot", rsp_quotient, 0);
      check_eq("rst_rem", rsp_remainder, 0);
      check_eq("rst_dividend", dividend, 0);
      check_eq("rst_divisor", divisor, 0);

      // Single request 75/10 on requester 0
      @(posedge clk); #1;
      req_dividend[31:0] = 32'd75;
      req_divisor[31:0]  = 32'd10;
      req_valid[0]       = 1'b1;
      @(negedge clk);
      check_eq("t1_ready_G", req_ready, 4'b0001);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      @(negedge clk);
      check_eq("t1_start_G1", start_division, 1);
      check_eq("t1_dividend", dividend, 75);
      check_eq("t1_divisor", divisor, 10);
      wait_rsp(100);
      check_eq("t1_rsp_valid", rsp_valid, 4'b0001);
      check_eq("t1_quot", rsp_quotient, 7);
      check_eq("t1_rem", rsp_remainder, 5);
      check_eq("t1_id", rsp_id, 0);
      @(negedge clk);
      check_eq("t1_strobe_once", rsp_valid, 0);
      check_eq("t1_hold_quot", rsp_quotient, 7);

      // All four at once after reset: order 0,1,2,3
      pulse_reset();
      grant_log.delete();
      fork
         drive_req(0, 32'd100, 32'd7, 500, g0);
         drive_req(1, 32'd81,  32'd9, 500, g1);
         drive_req(2, 32'd50,  32'd3, 500, g2);
         drive_req(3, 32'd9,   32'd10, 500, g3);
      join
      check_eq("t2_granted", {g0, g1, g2, g3}, 4'b1111);
      wait_rsp(100);
      check_eq("t2_count", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         for (int i = 0; i < 4; i++) check_eq("t2_order", grant_log[i], i);
      end

      // Requester 1 holds valid through two grants, requester 2 asks once
      grant_log.delete();
      fork
         begin
            drive_req(1, 32'd1000, 32'd3, 500, g1);
            drive_req(1, 32'd77, 32'd7, 500, g0);
         end
         drive_req(2, 32'hFFFF_FFFF, 32'd16, 500, g2);
      join
      check_eq("t4_granted", {g0, g1, g2}, 3'b111);
      wait_rsp(100);
      check_eq("t4_count", grant_log.size(), 3);
      if (grant_log.size() == 3) begin
         check_eq("t4_order0", grant_log[0], 1);
         check_eq("t4_order1", grant_log[1], 2);
         check_eq("t4_order2", grant_log[2], 1);
      end

      // Reset while waiting on the divider
      @(posedge clk); #1;
      req_dividend[31:0] = 32'd75;
      req_divisor[31:0]  = 32'd10;
      req_valid[0]       = 1'b1;
      @(negedge clk);
      check_eq("t5_ready", req_ready, 4'b0001);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      @(negedge clk);
      check_eq("t5_start", start_division, 1);
      for (int w = 0; w < 50 && start_division; w++) @(negedge clk);
      check_eq("t5_start_fell", start_division, 0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_eq("t5_busy", busy, 0);
      check_eq("t5_start_after", start_division, 0);
      check_eq("t5_rsp_valid", rsp_valid, 0);
      check_eq("t5_quot_cleared", rsp_quotient, 0);
      check_eq("t5_dividend_cleared", dividend, 0);
      @(posedge clk); #1;
      drive_req(0, 32'd75, 32'd10, 50, g0);
      check_eq("t5_regrant", g0, 1);
      wait_rsp(100);
      check_eq("t5_quot", rsp_quotient, 7);
      check_eq("t5_rem", rsp_remainder, 5);

      // Zero divisor 123/0
      @(posedge clk); #1;
      req_dividend[31:0] = 32'd123;
      req_divisor[31:0]  = 32'd0;
      req_valid[0]       = 1'b1;
      @(negedge clk);
      check_eq("t6_ready", req_ready, 4'b0001);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      @(negedge clk);
      if (GUARD) begin
         check_eq("t6_no_start_G1", start_division, 0);
         check_eq("t6_no_rsp_G1", rsp_valid, 0);
         @(negedge clk);
         check_eq("t6_rsp_G2", rsp_valid, 4'b0001);
         check_eq("t6_no_start_G2", start_division, 0);
         check_eq("t6_dbz", rsp_div_by_zero, 1);
      end else begin
         check_eq("t6_start_G1", start_division, 1);
         wait_rsp(100);
         check_eq("t6_dbz", rsp_div_by_zero, 0);
      end
      check_eq("t6_quot", rsp_quotient, 32'hFFFF_FFFF);
      check_eq("t6_rem", rsp_remainder, 123);

      // Randomized traffic from all requesters
      fork
         req_stream(0, 10);
         req_stream(1, 10);
         req_stream(2, 10);
         req_stream(3, 10);
      join
      for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
      check_eq("drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // ---------------- final report on runaway ----------------
   initial begin
      #400000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
